// File: rtl/arp_phase_sequencer.sv
// Sine-table address generator: steps the BRAM read address at a switch-selected pitch,
// optionally cycling root / major third / fifth / octave every NOTE_TICKS cycles.
module arp_phase_sequencer #(
  parameter int unsigned BASE_OFFSET = 746,
  parameter int unsigned NOTE_TICKS  = 50000000,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DIV_W       = 13
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic [7:0]        sw,
  input  logic              arp_toggle,
  output logic [ADDR_W-1:0] addr,
  output logic              step,
  output logic              arp_on,
  output logic [1:0]        note
);

  localparam int unsigned        DWELL_W      = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST   = DWELL_W'(NOTE_TICKS - 1);
  localparam logic [DIV_W-1:0]   RESET_TARGET = DIV_W'(2 * BASE_OFFSET);

  typedef enum logic [1:0] {
    NOTE0 = 2'd0,
    NOTE1 = 2'd1,
    NOTE2 = 2'd2,
    NOTE3 = 2'd3
  } note_e;

  note_e               note_q, note_d;
  logic                arp_on_q, arp_on_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]    target_q, target_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                step_q, step_d;
  logic                step_now;
  logic                note_change;

  // Half-period divisor for a note; 8P peaks at 8008, which still fits in DIV_W bits.
  function automatic logic [DIV_W-1:0] note_divisor(input note_e n, input logic [7:0] s);
    logic [DIV_W-1:0] p;
    p = DIV_W'(BASE_OFFSET) + {{(DIV_W-8){1'b0}}, s};
    case (n)
      NOTE0:   note_divisor = p << 1;
      NOTE1:   note_divisor = (p << 3) / DIV_W'(5);
      NOTE2:   note_divisor = (p << 2) / DIV_W'(3);
      NOTE3:   note_divisor = p;
      default: note_divisor = p << 1;
    endcase
  endfunction

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      note_q      <= NOTE0;
      arp_on_q    <= 1'b0;
      dwell_cnt_q <= '0;
      div_cnt_q   <= '0;
      target_q    <= RESET_TARGET;
      addr_q      <= '0;
      step_q      <= 1'b0;
    end else begin
      note_q      <= note_d;
      arp_on_q    <= arp_on_d;
      dwell_cnt_q <= dwell_cnt_d;
      div_cnt_q   <= div_cnt_d;
      target_q    <= target_d;
      addr_q      <= addr_d;
      step_q      <= step_d;
    end
  end

  always_comb begin
    note_d      = note_q;
    arp_on_d    = arp_on_q ^ arp_toggle;
    dwell_cnt_d = dwell_cnt_q;
    note_change = 1'b0;
    step_now    = (div_cnt_q == target_q - DIV_W'(1));
    step_d      = step_now;
    addr_d      = addr_q + ADDR_W'(step_now);

    // A toggle restarts at the root and wins over a coincident dwell terminal.
    if (arp_toggle) begin
      note_d      = NOTE0;
      dwell_cnt_d = '0;
      note_change = 1'b1;
    end else if (arp_on_q) begin
      if (dwell_cnt_q == DWELL_LAST) begin
        dwell_cnt_d = '0;
        note_change = 1'b1;
        case (note_q)
          NOTE0:   note_d = NOTE1;
          NOTE1:   note_d = NOTE2;
          NOTE2:   note_d = NOTE3;
          NOTE3:   note_d = NOTE0;
          default: note_d = NOTE0;
        endcase
      end else begin
        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
      end
    end else begin
      note_d      = NOTE0;
      dwell_cnt_d = '0;
    end

    // addr is never cleared on a note change so the waveform stays phase-continuous.
    if (step_now || note_change) begin
      div_cnt_d = '0;
      target_d  = note_divisor(note_d, sw);
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      target_d  = target_q;
    end
  end

  assign addr   = addr_q;
  assign step   = step_q;
  assign arp_on = arp_on_q;
  assign note   = note_q;

endmodule
